// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl: stall sources in,
// per-register hold/NOP vectors, PC redirect and perf count out.
interface pipe_ctrl_if #(
  parameter int MC_W   = 6,
  parameter int PERF_W = 32
);
  logic              if_req;
  logic              id_req;
  logic              mem_req;
  logic              ex_mc_start;
  logic [MC_W-1:0]   ex_mc_len;
  logic              ex_br_taken;
  logic [31:0]       ex_br_target;
  logic [4:0]        stall;
  logic [4:0]        bubble;
  logic              pc_redirect;
  logic [31:0]       pc_target;
  logic              mc_busy;
  logic [PERF_W-1:0] perf_stall_cnt;

  modport master (
    output if_req, id_req, mem_req, ex_mc_start, ex_mc_len, ex_br_taken, ex_br_target,
    input  stall, bubble, pc_redirect, pc_target, mc_busy, perf_stall_cnt
  );

  modport slave (
    input  if_req, id_req, mem_req, ex_mc_start, ex_mc_len, ex_br_taken, ex_br_target,
    output stall, bubble, pc_redirect, pc_target, mc_busy, perf_stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall priority, multi-cycle EX timing, branch redirect.
// Optional stalled-cycle counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MC_W   = 6,
  parameter int PERF_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_MC  = 2'd1,
    ST_RDW = 2'd2
  } state_e;

  localparam logic [MC_W-1:0] MC_ONE = {{(MC_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [MC_W-1:0] cnt_q, cnt_d;
  logic [31:0]     tgt_q, tgt_d;

  logic        mc_start;
  logic        mc_stall;
  logic [2:0]  lvl;
  logic [4:0]  stall_c;
  logic [4:0]  bubble_c;
  logic        redirect_c;
  logic [31:0] target_c;

  // A multi-cycle start is only honoured from RUN; EX cannot issue one otherwise.
  assign mc_start = bus.ex_mc_start && (bus.ex_mc_len != '0) && (state_q == ST_RUN);
  assign mc_stall = mc_start || (state_q == ST_MC);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    stall_c    = '0;
    bubble_c   = '0;
    redirect_c = 1'b0;
    target_c   = '0;

    if      (bus.mem_req) lvl = 3'd4;
    else if (mc_stall)    lvl = 3'd3;
    else if (bus.id_req)  lvl = 3'd2;
    else if (bus.if_req)  lvl = 3'd1;
    else                  lvl = 3'd0;

    if (lvl != 3'd0) begin
      stall_c  = (5'd1 << lvl) - 5'd1;
      bubble_c = 5'd1 << lvl;
    end

    unique case (state_q)
      ST_RUN: begin
        if (mc_start && (bus.ex_mc_len > MC_ONE)) begin
          state_d = ST_MC;
          cnt_d   = bus.ex_mc_len - MC_ONE;
        end
        // A branch behind a MEM stall stays in EX and re-presents later.
        if (bus.ex_br_taken && (lvl != 3'd4)) begin
          bubble_c[2:1] = 2'b11;
          if (!bus.if_req) begin
            redirect_c    = 1'b1;
            target_c      = bus.ex_br_target;
            stall_c[2:0]  = 3'b000;
          end else begin
            tgt_d   = bus.ex_br_target;
            state_d = ST_RDW;
          end
        end
      end
      ST_MC: begin
        cnt_d = cnt_q - MC_ONE;
        if (cnt_q <= MC_ONE) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RDW: begin
        bubble_c[1] = 1'b1;
        if ((lvl != 3'd4) && !bus.if_req) begin
          redirect_c = 1'b1;
          target_c   = tgt_q;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (rst) begin
      stall_c    = '0;
      bubble_c   = '0;
      redirect_c = 1'b0;
      target_c   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.bubble      = bubble_c;
  assign bus.pc_redirect = redirect_c;
  assign bus.pc_target   = target_c;
  assign bus.mc_busy     = mc_stall && !rst;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] perf_q, perf_d;

  // Saturates at all-ones instead of wrapping.
  always_comb begin
    perf_d = perf_q;
    if (stall_c[0] && (perf_q != '1)) perf_d = perf_q + PERF_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign bus.perf_stall_cnt = rst ? '0 : perf_q;
`else
  assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; expected values are hand-computed.
module tb_pipe_ctrl;

  localparam int MC_W   = 6;
  localparam int PERF_W = 32;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd6;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  pipe_ctrl_if #(.MC_W(MC_W), .PERF_W(PERF_W)) bus ();

  pipe_ctrl #(.MC_W(MC_W), .PERF_W(PERF_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req       = 1'b0;
    bus.id_req       = 1'b0;
    bus.mem_req      = 1'b0;
    bus.ex_mc_start  = 1'b0;
    bus.ex_mc_len    = '0;
    bus.ex_br_taken  = 1'b0;
    bus.ex_br_target = '0;
  endtask

  // EX never starts a multi-cycle op or branches while held in MC/RDW.
  always @(posedge clk) begin
    if (!rst) begin
      if (((dut.state_q == 2'd2) && (bus.ex_mc_start || bus.ex_br_taken)) ||
          ((dut.state_q == 2'd1) && bus.ex_br_taken)) begin
        n_mis++;
        $error("FAIL illegal_ex_event: state %0d start %0b br %0b",
               dut.state_q, bus.ex_mc_start, bus.ex_br_taken);
      end
    end
  end

  initial begin
    idle();
    rst              = 1'b1;
    bus.id_req       = 1'b1;
    bus.mem_req      = 1'b1;
    bus.ex_br_taken  = 1'b1;
    bus.ex_br_target = 32'hdead_beef;
    bus.ex_mc_start  = 1'b1;
    bus.ex_mc_len    = 6'd5;
    #1;
    check("rst_stall",    32'(bus.stall),          32'h0);
    check("rst_bubble",   32'(bus.bubble),         32'h0);
    check("rst_redirect", 32'(bus.pc_redirect),    32'h0);
    check("rst_target",   bus.pc_target,           32'h0);
    check("rst_busy",     32'(bus.mc_busy),        32'h0);
    check("rst_perf",     32'(bus.perf_stall_cnt), 32'h0);
    tick();
    tick();

    // Stall priority: id alone, then mem on top.
    idle();
    rst        = 1'b0;
    bus.id_req = 1'b1;
    #1;
    check("id_stall",  32'(bus.stall),  32'b00011);
    check("id_bubble", 32'(bus.bubble), 32'b00100);
    bus.mem_req = 1'b1;
    #1;
    check("mem_stall",  32'(bus.stall),  32'b01111);
    check("mem_bubble", 32'(bus.bubble), 32'b10000);
    tick();
    idle();
    #1;
    check("idle_stall",  32'(bus.stall),  32'h0);
    check("idle_bubble", 32'(bus.bubble), 32'h0);

    // Multi-cycle op of length 4.
    bus.ex_mc_start = 1'b1;
    bus.ex_mc_len   = 6'd4;
    #1;
    check("mc4_c1_stall",  32'(bus.stall),   32'b00111);
    check("mc4_c1_bubble", 32'(bus.bubble),  32'b01000);
    check("mc4_c1_busy",   32'(bus.mc_busy), 32'h1);
    tick();
    idle();
    for (int c = 2; c <= 4; c++) begin
      #1;
      check($sformatf("mc4_c%0d_stall", c),  32'(bus.stall),   32'b00111);
      check($sformatf("mc4_c%0d_bubble", c), 32'(bus.bubble),  32'b01000);
      check($sformatf("mc4_c%0d_busy", c),   32'(bus.mc_busy), 32'h1);
      tick();
    end
    check("mc4_c5_stall", 32'(bus.stall),   32'h0);
    check("mc4_c5_busy",  32'(bus.mc_busy), 32'h0);

    // Length 0: no stall at all.
    bus.ex_mc_start = 1'b1;
    bus.ex_mc_len   = 6'd0;
    #1;
    check("mc0_stall", 32'(bus.stall),   32'h0);
    check("mc0_busy",  32'(bus.mc_busy), 32'h0);
    tick();
    idle();
    #1;
    check("mc0_next_stall", 32'(bus.stall), 32'h0);

    // Length 1: exactly one stall cycle, no MC state.
    bus.ex_mc_start = 1'b1;
    bus.ex_mc_len   = 6'd1;
    #1;
    check("mc1_stall", 32'(bus.stall),   32'b00111);
    check("mc1_busy",  32'(bus.mc_busy), 32'h1);
    tick();
    idle();
    #1;
    check("mc1_next_stall", 32'(bus.stall),   32'h0);
    check("mc1_next_busy",  32'(bus.mc_busy), 32'h0);

    // Taken branch with fetch ready: immediate redirect.
    bus.ex_br_taken  = 1'b1;
    bus.ex_br_target = 32'h0000_1000;
    #1;
    check("br_redirect", 32'(bus.pc_redirect), 32'h1);
    check("br_target",   bus.pc_target,        32'h0000_1000);
    check("br_bubble",   32'(bus.bubble),      32'b00110);
    check("br_stall",    32'(bus.stall),       32'h0);
    tick();
    idle();
    #1;
    check("br_after_redirect", 32'(bus.pc_redirect), 32'h0);
    check("br_after_target",   bus.pc_target,        32'h0);

    // Taken branch with fetch outstanding for 3 cycles: redirect waits.
    bus.ex_br_taken  = 1'b1;
    bus.ex_br_target = 32'h0000_2000;
    bus.if_req       = 1'b1;
    #1;
    check("rdw_c1_redirect", 32'(bus.pc_redirect), 32'h0);
    check("rdw_c1_bubble",   32'(bus.bubble),      32'b00110);
    check("rdw_c1_stall",    32'(bus.stall),       32'b00001);
    check("rdw_c1_target",   bus.pc_target,        32'h0);
    tick();
    idle();
    bus.if_req = 1'b1;
    for (int c = 2; c <= 3; c++) begin
      #1;
      check($sformatf("rdw_c%0d_bubble1", c),  32'(bus.bubble[1]),   32'h1);
      check($sformatf("rdw_c%0d_redirect", c), 32'(bus.pc_redirect), 32'h0);
      tick();
    end
    bus.if_req = 1'b0;
    #1;
    check("rdw_fall_redirect", 32'(bus.pc_redirect), 32'h1);
    check("rdw_fall_target",   bus.pc_target,        32'h0000_2000);
    check("rdw_fall_bubble",   32'(bus.bubble),      32'b00010);
    tick();
    #1;
    check("rdw_done_redirect", 32'(bus.pc_redirect), 32'h0);
    check("rdw_done_bubble",   32'(bus.bubble),      32'h0);

    // RDW with a MEM stall: redirect waits for level below 4.
    bus.ex_br_taken  = 1'b1;
    bus.ex_br_target = 32'h0000_3000;
    bus.if_req       = 1'b1;
    tick();
    idle();
    bus.mem_req = 1'b1;
    #1;
    check("rdwm_redirect", 32'(bus.pc_redirect), 32'h0);
    check("rdwm_stall",    32'(bus.stall),       32'b01111);
    check("rdwm_bubble",   32'(bus.bubble),      32'b10010);
    tick();
    bus.mem_req = 1'b0;
    #1;
    check("rdwm_redirect2", 32'(bus.pc_redirect), 32'h1);
    check("rdwm_target2",   bus.pc_target,        32'h0000_3000);
    tick();

    // Branch at level 4 is ignored.
    bus.ex_br_taken  = 1'b1;
    bus.ex_br_target = 32'h0000_4000;
    bus.mem_req      = 1'b1;
    #1;
    check("brk4_redirect", 32'(bus.pc_redirect), 32'h0);
    check("brk4_stall",    32'(bus.stall),       32'b01111);
    check("brk4_bubble",   32'(bus.bubble),      32'b10000);
    tick();
    idle();
    #1;
    check("brk4_next_redirect", 32'(bus.pc_redirect), 32'h0);
    check("brk4_next_bubble",   32'(bus.bubble),      32'h0);

    // MEM stall during MC: countdown continues underneath.
    bus.ex_mc_start = 1'b1;
    bus.ex_mc_len   = 6'd3;
    #1;
    check("mcm_c1_stall", 32'(bus.stall), 32'b00111);
    tick();
    idle();
    bus.mem_req = 1'b1;
    #1;
    check("mcm_c2_stall", 32'(bus.stall),   32'b01111);
    check("mcm_c2_busy",  32'(bus.mc_busy), 32'h1);
    tick();
    bus.mem_req = 1'b0;
    #1;
    check("mcm_c3_stall", 32'(bus.stall),   32'b00111);
    check("mcm_c3_busy",  32'(bus.mc_busy), 32'h1);
    tick();
    check("mcm_c4_stall", 32'(bus.stall),   32'h0);
    check("mcm_c4_busy",  32'(bus.mc_busy), 32'h0);

    // Reset while MC cnt is 2 abandons the op.
    bus.ex_mc_start = 1'b1;
    bus.ex_mc_len   = 6'd4;
    tick();
    idle();
    tick();
    rst        = 1'b1;
    bus.id_req = 1'b1;
    #1;
    check("rstmc_stall",    32'(bus.stall),       32'h0);
    check("rstmc_bubble",   32'(bus.bubble),      32'h0);
    check("rstmc_busy",     32'(bus.mc_busy),     32'h0);
    check("rstmc_redirect", 32'(bus.pc_redirect), 32'h0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rstmc_rel_stall", 32'(bus.stall),          32'h0);
    check("rstmc_rel_busy",  32'(bus.mc_busy),        32'h0);
    check("rstmc_rel_perf",  32'(bus.perf_stall_cnt), 32'h0);
    tick();
    check("rstmc_rel2_stall", 32'(bus.stall),   32'h0);
    check("rstmc_rel2_busy",  32'(bus.mc_busy), 32'h0);

    // Perf count: 4-cycle op plus 2 mem stall cycles.
    bus.ex_mc_start = 1'b1;
    bus.ex_mc_len   = 6'd4;
    tick();
    idle();
    tick();
    tick();
    tick();
    bus.mem_req = 1'b1;
    tick();
    tick();
    idle();
    #1;
    check("perf_cnt", 32'(bus.perf_stall_cnt), PERF_EXP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. Collects stall requests from IF, ID, EX and MEM, times multi-cycle EX operations, and handles taken-branch redirects. Drives per-register hold (`stall`) and NOP-insert (`bubble`) vectors to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Register index: R0=PC, R1=IF/ID, R2=ID/EX, R3=EX/MEM, R4=MEM/WB.

## Interface
- `MC_W`, 6: width of the multi-cycle length and down-counter.
- `PERF_W`, 32: width of the stall performance counter.

- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: IF fetch outstanding, instruction not ready (stage level 1).
- `id_req` in 1: load-use hazard in ID (level 2).
- `mem_req` in 1: MEM data access not complete (level 4).
- `ex_mc_start` in 1: EX begins a multi-cycle op this cycle.
- `ex_mc_len` in MC_W: stall cycles required by that op, sampled with `ex_mc_start`.
- `ex_br_taken` in 1: branch/jump in EX resolved taken.
- `ex_br_target` in 32: redirect address, valid with `ex_br_taken`.
- `stall` out 5: bit i holds register Ri.
- `bubble` out 5: bit i loads NOP into Ri.
- `pc_redirect` out 1: load `pc_target` into PC this cycle.
- `pc_target` out 32: redirect address.
- `mc_busy` out 1: multi-cycle op in progress.
- `perf_stall_cnt` out PERF_W: stalled-cycle count (see Configuration).

## Operation
- Stall level k is the highest active source: `mem_req`→4, EX multi-cycle stall→3, `id_req`→2, `if_req`→1, none→0.
- For k>0: `stall` = (1<<k)-1, `bubble` = 1<<k. For k=0: both 0. Lower-level requests are masked.
- EX multi-cycle stall is active when `ex_mc_start` is high with `ex_mc_len`≠0, or when the state is MC.
- States:
  - RUN: default.
  - MC: multi-cycle countdown.
  - RDW: redirect wait.
- RUN→MC:
  - Occurs on `ex_mc_start` with `ex_mc_len`≥2; `cnt` loads `ex_mc_len`-1.
  - With `ex_mc_len`=1, the stall lasts one cycle and the state stays RUN.
  - With `ex_mc_len`=0, there is no stall.
- MC:
  - `cnt` decrements every cycle, regardless of `mem_req`.
  - When `cnt` is 1 (i.e. it will reach 0), the EX stall is still asserted that cycle and the state goes to RUN next cycle.
  - Total EX stall equals `ex_mc_len` cycles.
- Branch, evaluated only when k<4. At k=4 the branch is ignored; it stays held in EX and re-presents.
  - Taken with `if_req`=0:
    - `pc_redirect`=1 and `pc_target`=`ex_br_target` in the same cycle.
    - `bubble[1]` and `bubble[2]` are forced to 1, and `stall[0..2]` to 0.
  - Taken with `if_req`=1:
    - `bubble[1]` and `bubble[2]` are forced to 1.
    - The target is latched into `tgt_q` and the state goes to RDW.
    - `pc_redirect`=0 this cycle.
- RDW:
  - `bubble[1]`=1 every cycle, which discards the in-flight wrong-path fetch.
  - On the first cycle with `if_req`=0: `pc_redirect`=1, `pc_target`=`tgt_q`, next state RUN.
  - `mem_req` in RDW still stalls R0–R3 per level 4; `pc_redirect` waits for k<4.
- `ex_mc_start` or `ex_br_taken` in RDW, and `ex_br_taken` in MC, cannot occur (EX holds a bubble or the multi-cycle op). They are ignored and flagged by a bench assertion.
- `mc_busy` = (state==MC) | (`ex_mc_start` & `ex_mc_len`≠0).
- `pc_target` = 0 whenever `pc_redirect`=0.

## Timing
- `stall`, `bubble`, `pc_redirect`, `pc_target` and `mc_busy` are combinational from the inputs and the current state, with zero latency.
- State, `cnt`, `tgt_q` and the perf counter update on posedge `clk`.
- While `rst`=1:
  - All outputs are 0.
  - Next state is RUN; `cnt`=0, `tgt_q`=0, `perf_stall_cnt`=0.
- Reset mid-MC or mid-RDW abandons the op or redirect; there is no pending action after release.
- `mem_req` during MC: level 4 dominates, and the countdown continues hidden beneath it.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `perf_stall_cnt` increments on every non-reset cycle with `stall[0]`=1.
  - The counter saturates at all-ones.
- Not defined: no counter register; `perf_stall_cnt` is tied to 0.

## Test plan
- `id_req`=1 for one cycle → `stall`=5'b00011, `bubble`=5'b00100. Adding `mem_req`=1 the same cycle → `stall`=5'b01111, `bubble`=5'b10000.
- `ex_mc_start`=1, `ex_mc_len`=4 → `stall`=5'b00111 and `bubble`=5'b01000 for exactly 4 cycles; `mc_busy` high for those 4; RUN on cycle 5. Repeat with `ex_mc_len`=0 → no stall.
- `ex_br_taken`=1, `ex_br_target`=0x0000_1000, `if_req`=0 → same cycle `pc_redirect`=1, `pc_target`=0x1000, `bubble`=5'b00110.
- Branch with `if_req`=1 held 3 cycles → `bubble[1]`=1 for all 3 cycles, `pc_redirect`=0; on the cycle `if_req` falls, `pc_redirect`=1 with the latched target.
- `rst` asserted at MC `cnt`=2 → all outputs 0 during reset; after release with no requests, `stall`=0 and `mc_busy`=0.
- With `PIPE_CTRL_PERF_EN`: 4-cycle multi-cycle op plus 2 `mem_req` cycles → `perf_stall_cnt`=6.
